// File: rtl/apb3_irq_scheduler_pkg.sv
// APB3 interrupt scheduler: shared constants.
// Register offsets, CTRL bit positions, run-state encoding.
package apb3_irq_scheduler_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/apb3_irq_scheduler_if.sv
// APB3 bus bundle for the interrupt scheduler.
// master drives the request, slave drives the response.
interface apb3_irq_scheduler_if #(
  parameter int ADDR_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERROR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface

// File: rtl/apb3_irq_prescaler.sv
// Prescaler: counts 0..limit, ticks on the limit value.
// A limit lowered below the count ticks at once.
module apb3_irq_prescaler #(
  parameter int PRE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [PRE_WIDTH-1:0] limit,
  output logic                 tick
);
  logic [PRE_WIDTH-1:0] cnt_q;

  assign tick = enable && (cnt_q >= limit);

  // Free-running divider, restarted by clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/apb3_irq_scheduler.sv
// APB3 interrupt scheduler top: regs, run FSM, event count.
// Emits a level irq and a one-cycle event strobe per expiry.
module apb3_irq_scheduler
  import apb3_irq_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int PRE_WIDTH    = 16,
  parameter int PRESCALE_RST = 99,
  parameter int COMPARE_RST  = 0
) (
  input  logic                clk,
  input  logic                reset,
  apb3_irq_scheduler_if.slave apb,
  output logic                irq,
  output logic                event_pulse
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            off;
  logic                  unused_addr;
  logic                  setup, access, mapped;
  logic                  wr, wr_ctrl, wr_pre, wr_cmp, wr_stat;
  logic [2:0]            ctrl_q;
  logic [PRE_WIDTH-1:0]  pre_q;
  logic [CNT_WIDTH-1:0]  cmp_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  pend_q;
  logic                  tick, expiry, running;
  logic [31:0]           rdata;
  state_t                state_q, state_d;

  assign paddr       = apb.PADDR;
  assign off         = paddr[4:2];
  assign unused_addr = ^paddr[ADDR_WIDTH-1:5];

  assign setup  = apb.PSEL && !apb.PENABLE;
  assign access = apb.PSEL && apb.PENABLE;
  assign mapped = (paddr[1:0] == 2'b00)
               && (off <= OFF_STATUS);

  assign wr      = access && apb.PWRITE && mapped;
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign wr_pre  = wr && (off == OFF_PRESCALE);
  assign wr_cmp  = wr && (off == OFF_COMPARE);
  assign wr_stat = wr && (off == OFF_STATUS);

  assign apb.PREADY    = 1'b1;
  assign apb.PSLVERROR = access && !mapped;

  assign running = (state_q == ST_RUN);
  assign expiry  = tick && (cnt_q >= cmp_q);
  assign irq     = pend_q && ctrl_q[CTRL_IRQ_EN];

  apb3_irq_prescaler #(
    .PRE_WIDTH(PRE_WIDTH)
  ) u_pre (
    .clk   (clk),
    .reset (reset),
    .clear (wr_ctrl),
    .enable(running),
    .limit (pre_q),
    .tick  (tick)
  );

  // Run-state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: CTRL writes win over a one-shot expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (wr_ctrl && apb.PWDATA[CTRL_EN])
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wr_ctrl && !apb.PWDATA[CTRL_EN])
          state_d = ST_IDLE;
        else if (expiry && !ctrl_q[CTRL_PERIODIC])
          state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config registers; one-shot expiry drops EN.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      pre_q  <= PRE_WIDTH'(PRESCALE_RST);
      cmp_q  <= CNT_WIDTH'(COMPARE_RST);
    end else begin
      if (wr_ctrl)
        ctrl_q <= apb.PWDATA[2:0];
      else if (expiry && !ctrl_q[CTRL_PERIODIC])
        ctrl_q[CTRL_EN] <= 1'b0;
      if (wr_pre) pre_q <= apb.PWDATA[PRE_WIDTH-1:0];
      if (wr_cmp) cmp_q <= apb.PWDATA[CNT_WIDTH-1:0];
    end
  end

  // Event counter, restarted by any CTRL write.
  always_ff @(posedge clk) begin
    if (reset || wr_ctrl)
      cnt_q <= '0;
    else if (tick)
      cnt_q <= expiry ? '0 : cnt_q + 1'b1;
  end

  // Pending flag (set beats W1C) and event strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      pend_q      <= (pend_q && !(wr_stat && apb.PWDATA[0]))
                  || expiry;
      event_pulse <= expiry;
    end
  end

  // Read mux; unmapped offsets read 0.
  always_comb begin
    rdata = '0;
    if (mapped) begin
      unique case (off)
        OFF_CTRL:     rdata = 32'(ctrl_q);
        OFF_PRESCALE: rdata = 32'(pre_q);
        OFF_COMPARE:  rdata = 32'(cmp_q);
        OFF_COUNT:    rdata = 32'(cnt_q);
        OFF_STATUS:   rdata = {30'd0, running, pend_q};
        default:      rdata = '0;
      endcase
    end
  end

  // Read data captured in setup, held through access.
  always_ff @(posedge clk) begin
    if (reset)      apb.PRDATA <= '0;
    else if (setup) apb.PRDATA <= rdata;
  end
endmodule

// File: tb/tb_apb3_irq_scheduler.sv
// Bench for apb3_irq_scheduler: APB tasks plus a
// pulse scoreboard of expected strobe cycles.
module tb_apb3_irq_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic irq, event_pulse;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];
  int unsigned last_edge;
  logic        last_err;
  logic [31:0] rd;

  apb3_irq_scheduler_if #(.ADDR_WIDTH(16)) apb ();

  apb3_irq_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .apb        (apb),
    .irq        (irq),
    .event_pulse(event_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step(1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    apb.PADDR = a; apb.PWDATA = d; apb.PWRITE = 1'b1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    step(1);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    last_err = apb.PSLVERROR;
    step(1);
    last_edge = cyc;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic rdx(input logic [15:0] a);
    apb.PADDR = a; apb.PWRITE = 1'b0;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    step(1);
    apb.PENABLE = 1'b1;
    @(negedge clk);
    rd = apb.PRDATA;
    last_err = apb.PSLVERROR;
    step(1);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wait_sb(input int budget, input string nm);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulses missing, required 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    checks++;
    if ({irq, event_pulse, apb.PSLVERROR} !== 3'b000 ||
        apb.PRDATA !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got irq=%b pulse=%b err=%b rd=%h required 0",
               irq, event_pulse, apb.PSLVERROR, apb.PRDATA);
    end
    rdx(16'h04);
    checks++;
    if (rd !== 32'd99) begin
      errors++; $display("FAIL reset_prescale: got %0d required 99", rd);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_status: got %h required 0", rd);
    end
    rdx(16'h08);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL reset_compare: got %h required 0", rd);
    end
  endtask

  task automatic test_periodic();
    int unsigned e;
    wr(16'h04, 1);
    wr(16'h08, 3);
    wr(16'h00, 32'h7);
    e = last_edge;
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 16);
    exp_q.push_back(e + 24);
    for (int i = 0; i < 20 && exp_q.size() > 2; i++) step(1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL periodic_irq: got %b required 1", irq);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h3) begin
      errors++; $display("FAIL periodic_status: got %h required 3", rd);
    end
    wait_sb(30, "periodic_pulses");
    wr(16'h00, 0);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL mask_irq: got %b required 0", irq);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL mask_pending: got %h required 1", rd);
    end
  endtask

  task automatic test_w1c();
    wr(16'h00, 32'h4);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL unmask_irq: got %b required 1", irq);
    end
    wr(16'h10, 1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL w1c_irq: got %b required 0", irq);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL w1c_status: got %h required 0", rd);
    end
  endtask

  task automatic test_oneshot();
    wr(16'h04, 0);
    wr(16'h08, 4);
    wr(16'h00, 32'h5);
    exp_q.push_back(last_edge + 5);
    wait_sb(20, "oneshot_pulse");
    rdx(16'h00);
    checks++;
    if (rd !== 32'h4) begin
      errors++; $display("FAIL oneshot_ctrl: got %h required 4", rd);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h1) begin
      errors++; $display("FAIL oneshot_status: got %h required 1", rd);
    end
    step(100);
    rdx(16'h0C);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL oneshot_count: got %h required 0", rd);
    end
  endtask

  task automatic test_collision();
    int unsigned e;
    wr(16'h10, 1);
    wr(16'h08, 9);
    wr(16'h00, 32'h7);
    e = last_edge;
    exp_q.push_back(e + 10);
    exp_q.push_back(e + 20);
    wait_until(e + 18);
    wr(16'h10, 1);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL collide_irq: got %b required 1", irq);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h3) begin
      errors++; $display("FAIL collide_status: got %h required 3", rd);
    end
    wr(16'h00, 0);
    wait_sb(5, "collide_pulses");
  endtask

  task automatic test_shrink();
    int unsigned e;
    wr(16'h08, 100);
    wr(16'h00, 32'h3);
    e = last_edge;
    wait_until(e + 40);
    rdx(16'h0C);
    checks++;
    if (rd !== 32'd40) begin
      errors++; $display("FAIL shrink_count40: got %0d required 40", rd);
    end
    wait_until(e + 48);
    wr(16'h08, 10);
    exp_q.push_back(e + 51);
    wait_sb(10, "shrink_pulse");
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL shrink_masked: got %b required 0", irq);
    end
    wr(16'h00, 0);
    rdx(16'h0C);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL stop_count: got %0d required 0", rd);
    end
    step(30);
    rdx(16'h0C);
    checks++;
    if (rd !== 32'd0) begin
      errors++; $display("FAIL stop_hold: got %0d required 0", rd);
    end
  endtask

  task automatic test_error();
    rdx(16'h14);
    checks++;
    if (last_err !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL err_read14: got err=%b rd=%h required err=1 rd=0",
               last_err, rd);
    end
    wr(16'h18, 32'hFFFF_FFFF);
    checks++;
    if (last_err !== 1'b1) begin
      errors++; $display("FAIL err_write18: got %b required 1", last_err);
    end
    rdx(16'h05);
    checks++;
    if (last_err !== 1'b1 || rd !== 32'd0) begin
      errors++;
      $display("FAIL err_misalign: got err=%b rd=%h required err=1 rd=0",
               last_err, rd);
    end
    wr(16'h01, 32'h7);
    step(20);
    rdx(16'h00);
    checks++;
    if (last_err !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_ctrl: got err=%b rd=%h required err=0 rd=0",
               last_err, rd);
    end
    rdx(16'h04);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL err_prescale: got %h required 0", rd);
    end
    rdx(16'h08);
    checks++;
    if (rd !== 32'd10) begin
      errors++; $display("FAIL err_compare: got %0d required 10", rd);
    end
  endtask

  task automatic test_reset_mid();
    wr(16'h00, 32'h7);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(30);
    rdx(16'h04);
    checks++;
    if (rd !== 32'd99) begin
      errors++; $display("FAIL midrst_prescale: got %0d required 99", rd);
    end
    rdx(16'h10);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL midrst_status: got %h irq=%b required 0", rd, irq);
    end
  endtask

  initial begin
    reset = 1'b1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    step(1);
    fork
      forever begin
        int unsigned ex;
        @(negedge clk);
        if (!reset && event_pulse) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: got pulse at %0d required none",
                     cyc);
          end else begin
            ex = exp_q.pop_front();
            if (cyc !== ex) begin
              errors++;
              $display("FAIL pulse_cycle: got %0d required %0d", cyc, ex);
            end
          end
        end
      end
    join_none
    test_reset();
    test_periodic();
    test_w1c();
    test_oneshot();
    test_collision();
    test_shrink();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
